// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-flop sync, debounce, short/long press events.
// Optional auto-repeat in the LONG state when BTN_AUTOREPEAT_EN is defined.
module btn_conditioner #(
   parameter int DEBOUNCE_CYCLES = 270_000,
   parameter int LONG_CYCLES     = 27_000_000,
   parameter int REPEAT_CYCLES   = 2_700_000
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic btn_n,
   output logic btn_level,
   output logic press_pulse,
   output logic short_pulse,
   output logic long_pulse,
   output logic repeat_pulse
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(LONG_CYCLES + 1);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

   typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;

   logic          sync1_q, sync_q;
   logic [DW-1:0] db_cnt_q, db_cnt_d;
   logic          level_q, level_d;
   logic          rise, fall;
   state_t        state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          press_q, press_d;
   logic          short_q, short_d;
   logic          long_q, long_d;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         sync1_q  <= 1'b0;
         sync_q   <= 1'b0;
         db_cnt_q <= '0;
         level_q  <= 1'b0;
         state_q  <= IDLE;
         hold_q   <= '0;
         press_q  <= 1'b0;
         short_q  <= 1'b0;
         long_q   <= 1'b0;
      end else begin
         sync1_q  <= ~btn_n;
         sync_q   <= sync1_q;
         db_cnt_q <= db_cnt_d;
         level_q  <= level_d;
         state_q  <= state_d;
         hold_q   <= hold_d;
         press_q  <= press_d;
         short_q  <= short_d;
         long_q   <= long_d;
      end
   end

   // Any disagreement resets credit; level flips on the cycle count would hit the limit.
   always_comb begin
      level_d  = level_q;
      db_cnt_d = '0;
      if (sync_q != level_q) begin
         if (db_cnt_q == DB_LAST) level_d = sync_q;
         else db_cnt_d = db_cnt_q + 1'b1;
      end
      rise = level_d & ~level_q;
      fall = level_q & ~level_d;
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      unique case (state_q)
         IDLE: begin
            hold_d = '0;
            if (rise) begin
               state_d = HELD;
               hold_d  = HW'(1);
            end
         end
         HELD: begin
            if (fall) begin
               state_d = IDLE;
               hold_d  = '0;
            end else begin
               if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
               if (hold_q == HOLD_LAST) state_d = LONG;
            end
         end
         LONG: begin
            if (fall) begin
               state_d = IDLE;
               hold_d  = '0;
            end
         end
         default: begin
            state_d = IDLE;
            hold_d  = '0;
         end
      endcase
   end

   // A release completing on the long threshold wins over the long event.
   always_comb begin
      press_d = (state_q == IDLE) & rise;
      short_d = (state_q == HELD) & fall;
      long_d  = (state_q == HELD) & ~fall & (hold_q == HOLD_LAST);
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam int RW = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0] rep_cnt_q, rep_cnt_d;
   logic          rep_q, rep_d;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         rep_cnt_q <= '0;
         rep_q     <= 1'b0;
      end else begin
         rep_cnt_q <= rep_cnt_d;
         rep_q     <= rep_d;
      end
   end

   always_comb begin
      rep_cnt_d = '0;
      rep_d     = 1'b0;
      if (state_q == LONG && !fall) begin
         if (rep_cnt_q == REP_LAST) rep_d = 1'b1;
         else rep_cnt_d = rep_cnt_q + 1'b1;
      end
   end

   assign repeat_pulse = rep_q;
`else
   assign repeat_pulse = 1'b0 & (REPEAT_CYCLES != 0);
`endif

   assign btn_level   = level_q;
   assign press_pulse = press_q;
   assign short_pulse = short_q;
   assign long_pulse  = long_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE=4, LONG=20, REPEAT=5.
// Edge numbers count rising edges; an input is first sampled on its tick's edge.
module tb_btn_conditioner;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   logic btn_n   = 1'b1;
   logic btn_level, press_pulse, short_pulse, long_pulse, repeat_pulse;

   btn_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .LONG_CYCLES    (20),
      .REPEAT_CYCLES  (5)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .btn_n       (btn_n),
      .btn_level   (btn_level),
      .press_pulse (press_pulse),
      .short_pulse (short_pulse),
      .long_pulse  (long_pulse),
      .repeat_pulse(repeat_pulse)
   );

   always #5 sys_clk = ~sys_clk;

   int ecnt = 0;
   always @(posedge sys_clk) ecnt <= ecnt + 1;

   int n_chk = 0;
   int n_fail = 0;
   int n_press, n_short, n_long, n_rep, n_overlap = 0;
   int t_press, t_short, t_long, t_rep_first, t_rep_last;

   typedef struct {
      logic       b;
      logic [4:0] exp;
   } vec_t;
   vec_t vt[41];

   function automatic logic [4:0] outs();
      return {btn_level, press_pulse, short_pulse, long_pulse, repeat_pulse};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clr();
      n_press = 0; n_short = 0; n_long = 0; n_rep = 0;
      t_press = -1; t_short = -1; t_long = -1;
      t_rep_first = -1; t_rep_last = -1;
   endtask

   task automatic tick(input logic b);
      int s;
      btn_n = b;
      @(posedge sys_clk);
      #1;
      s = int'(press_pulse) + int'(short_pulse)
        + int'(long_pulse) + int'(repeat_pulse);
      if (s > 1) n_overlap++;
      if (press_pulse) begin n_press++; t_press = ecnt; end
      if (short_pulse) begin n_short++; t_short = ecnt; end
      if (long_pulse)  begin n_long++;  t_long  = ecnt; end
      if (repeat_pulse) begin
         if (n_rep == 0) t_rep_first = ecnt;
         n_rep++;
         t_rep_last = ecnt;
      end
   endtask

   task automatic ticks(input logic b, input int n);
      for (int i = 0; i < n; i++) tick(b);
   endtask

   int e0, d;

   initial begin
      // Clean press (low 2..11) then a 3-cycle glitch (low 28..30).
      for (int i = 0; i < 41; i++) begin
         vt[i].b   = !((i >= 2 && i < 12) || (i >= 28 && i <= 30));
         vt[i].exp = {(i >= 7 && i < 17), (i == 7), (i == 17), 1'b0, 1'b0};
      end
      clr();

      ticks(1'b1, 3);
      chk("reset_outputs", int'(outs()), 0);
      sys_rst = 1'b0;
      ticks(1'b1, 3);

      for (int i = 0; i < 41; i++) begin
         tick(vt[i].b);
         chk($sformatf("vec%0d", i), int'(outs()), int'(vt[i].exp));
      end

      // Bounce: 2-cycle toggles for 12 cycles, then held low.
      ticks(1'b1, 5);
      clr();
      for (int j = 0; j < 12; j++) tick((j % 4) >= 2);
      e0 = ecnt + 1;
      ticks(1'b0, 15);
      chk("bounce_press_cnt", n_press, 1);
      chk("bounce_press_t", t_press, e0 + 5);
      chk("bounce_no_long", n_long, 0);
      ticks(1'b1, 12);
      chk("bounce_short_cnt", n_short, 1);
      chk("bounce_level_low", int'(btn_level), 0);

      // Long hold of 40 cycles.
      ticks(1'b1, 5);
      clr();
      e0 = ecnt + 1;
      ticks(1'b0, 40);
      ticks(1'b1, 15);
      chk("hold_press_cnt", n_press, 1);
      chk("hold_press_t", t_press, e0 + 5);
      chk("hold_long_cnt", n_long, 1);
      chk("hold_long_t", t_long, e0 + 24);
      chk("hold_no_short", n_short, 0);
`ifdef BTN_AUTOREPEAT_EN
      chk("hold_rep_cnt", n_rep, 4);
      chk("hold_rep_first", t_rep_first, e0 + 29);
      chk("hold_rep_last", t_rep_last, e0 + 44);
`else
      chk("hold_rep_cnt", n_rep, 0);
`endif

      // Release debounce completes on the same edge hold reaches 20.
      ticks(1'b1, 5);
      clr();
      e0 = ecnt + 1;
      ticks(1'b0, 19);
      ticks(1'b1, 15);
      chk("tie_short_cnt", n_short, 1);
      chk("tie_short_t", t_short, e0 + 24);
      chk("tie_long_cnt", n_long, 0);

      // Asynchronous reset mid-HELD with the button still held.
      ticks(1'b1, 5);
      clr();
      ticks(1'b0, 10);
      chk("mid_level_high", int'(btn_level), 1);
      #3;
      sys_rst = 1'b1;
      #1;
      chk("async_rst_outputs", int'(outs()), 0);
      ticks(1'b0, 2);
      #2;
      sys_rst = 1'b0;
      d = ecnt;
      clr();
      ticks(1'b0, 10);
      chk("rst_repress_cnt", n_press, 1);
      chk("rst_repress_t", t_press, d + 6);
      ticks(1'b1, 10);
      chk("rst_release_short", n_short, 1);

      chk("pulse_overlap", n_overlap, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
